even_check_arbiter: RTL
=======================

// Module: even_check_arbiter
// PURPOSE
//   Shares one even-value detector (f = ~z, the LSB of x,y,z inverted) among N requesters.
//   Round-robin arbiter: grants one requester per cycle, registers its 3-bit operand,
//   presents f with requester id on a valid/ready result port, and counts even results.
//   Sits between the ch4 operand sources and a single result consumer.
// PARAMETERS
//   N     4   number of requesters (2..8)
//   W     3   operand width; bit 0 is z, the parity bit tested
//   CNTW  8   width of the even-result counter
// PORTS
//   clk         in   1       rising-edge clock
//   rst_b       in   1       asynchronous active-low reset
//   req         in   N       req[i]=1: requester i holds a valid operand
//   data        in   N*W     operand i on data[i*W +: W]; stable while req[i]=1
//   gnt         out  N       one-hot accept pulse; operand i captured on this edge
//   out_valid   out  1       result register holds an unconsumed result
//   out_rdy     in   1       consumer accepts the result when out_valid && out_rdy
//   out_f       out  1       1 = captured operand even (~data[0])
//   out_id      out  clog2N  index of the requester the result belongs to
//   out_data    out  W       captured operand
//   even_cnt    out  CNTW    count of even results consumed; saturates at all-ones
// BEHAVIOUR
//   Reset (rst_b=0, async): gnt=0, out_valid=0, out_f=0, out_id=0, out_data=0,
//     even_cnt=0, rr_ptr=0, state=IDLE. Reset mid-transfer discards the held result.
//   States: IDLE (result register empty), FULL (out_valid=1).
//   can_accept = (state==IDLE) | (out_valid & out_rdy).
//   gnt is combinational: when can_accept & |req, gnt = first set req bit at or after
//     rr_ptr, wrapping N-1 -> 0. Otherwise gnt=0. Never more than one bit set.
//   On an edge with a grant to i: out_data<=data[i], out_f<=~data[i*W], out_id<=i,
//     rr_ptr<=(i+1) mod N, state<=FULL. Latency: gnt in cycle t, out_valid in t+1.
//   FULL & out_rdy & no req: state<=IDLE, out_valid<=0. Output data may hold stale values.
//   FULL & out_rdy & req: consume and re-grant in the same cycle. Throughput is 1/clk.
//   FULL & !out_rdy: gnt=0; out_* hold; rr_ptr holds.
//   even_cnt increments on each consume (out_valid & out_rdy) with out_f=1.
//     It holds at 2^CNTW-1.
//   req dropped before its grant: no capture, no error. rr_ptr moves only on a grant.
//   out_rdy while out_valid=0: ignored.
// TESTING
//   1 reset, req=4'b0001, data0=3'd4, out_rdy=1 -> gnt=0001 in cycle 1;
//     cycle 2: out_valid=1, out_f=1, out_id=0, out_data=4; even_cnt=1 after consume.
//   2 req=4'b1111 held, data i=i+1, out_rdy=1 -> gnt order 0,1,2,3,0 on consecutive
//     cycles; out_f sequence 0,1,0,1; out_valid continuously 1.
//   3 req=4'b0100, out_rdy=0 for 3 cycles, then req=4'b1010 -> single gnt=0100;
//     out_* hold with out_id=2; gnt=0 until out_rdy=1; next grant is 1000 (ptr=3).
//   4 sweep data0=0..7 via req0 with out_rdy=1 -> out_f=1,0,1,0,1,0,1,0;
//     even_cnt=4.
//   5 CNTW=2, 5 even consumes -> even_cnt 1,2,3,3,3 (saturate).
//   6 assert rst_b=0 while out_valid=1 and gnt active -> immediately out_valid=0,
//     gnt=0, even_cnt=0; after release, req=4'b1000 -> gnt=1000 (ptr restarted at 0).

Source files
------------

// File: rtl/even_check_arbiter.sv
// even_check_arbiter
//   Round-robin arbiter sharing one even-value detector among N requesters.
//   The winning operand is captured into a one-deep result register and
//   presented with its requester id on a valid/ready port. Even results
//   are counted as they are consumed; the count saturates at all-ones.
// Ports
//   clk        rising-edge clock
//   rst_b      asynchronous active-low reset
//   req        per-requester operand valid
//   data       operand i on data[i*W +: W]; bit 0 is the parity bit
//   gnt        one-hot accept pulse (combinational); operand captured this edge
//   out_valid  result register holds an unconsumed result
//   out_rdy    consumer accepts when out_valid && out_rdy
//   out_f      1 = captured operand even
//   out_id     requester index of the held result
//   out_data   captured operand
//   even_cnt   saturating count of consumed even results
module even_check_arbiter #(
    parameter int N    = 4,
    parameter int W    = 3,
    parameter int CNTW = 8,
    localparam int IDW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  data,
    output logic [N-1:0]    gnt,
    output logic            out_valid,
    input  logic            out_rdy,
    output logic            out_f,
    output logic [IDW-1:0]  out_id,
    output logic [W-1:0]    out_data,
    output logic [CNTW-1:0] even_cnt
);

    typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_ptr;
    logic           can_accept;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic [W-1:0]   ops [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_unpack
            assign ops[gi] = data[gi*W +: W];
        end
    endgenerate

    // A slot opens either when empty or when the held result leaves this cycle.
    assign can_accept = (state_q == IDLE) || (out_valid && out_rdy);

    // Scan from rr_ptr upward with wrap; first set request wins. The grant is
    // forced off while reset is asserted so no spurious pulse escapes.
    always_comb begin
        logic [IDW:0] sum;
        logic [IDW-1:0] idx;
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N))
                sum = sum - (IDW+1)'(N);
            idx = sum[IDW-1:0];
            if (!grant_any && req[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
        if (!(can_accept && rst_b)) begin
            grant_any = 1'b0;
            grant_idx = '0;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        if (grant_any)
            state_d = FULL;
        else if (state_q == FULL && out_rdy)
            state_d = IDLE;
    end

    // Outputs
    always_comb begin
        gnt       = grant_any ? (N'(1) << grant_idx) : '0;
        out_valid = (state_q == FULL);
    end

    // Result register, pointer and counter
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_f    <= 1'b0;
            out_id   <= '0;
            out_data <= '0;
            rr_ptr   <= '0;
            even_cnt <= '0;
        end else begin
            if (grant_any) begin
                out_data <= ops[grant_idx];
                out_f    <= ~ops[grant_idx][0];
                out_id   <= grant_idx;
                rr_ptr   <= (grant_idx == IDW'(N-1)) ? '0 : grant_idx + IDW'(1);
            end
            if (out_valid && out_rdy && out_f && (even_cnt != '1))
                even_cnt <= even_cnt + CNTW'(1);
        end
    end

endmodule
